// File: rtl/penguenler.sv
// Penguin foraging race tracker; statistics register one edge after the last penguin fills (no backpressure).
// Optional PENGUEN_TIMEOUT_EN forces a still-hungry penguin done with time 127.
module penguenler (
  input  logic        saat,
  input  logic        reset,
  input  logic [14:0] avlanan_balik,
  output logic        bitti,
  output logic [6:0]  en_kisa,
  output logic [6:0]  en_uzun,
  output logic [6:0]  ortalama,
  output logic [2:0]  hizli_penguen,
  output logic [2:0]  yavas_penguen
);

  localparam int NP = 5;

  logic [4:0]    store_q [NP];
  logic [4:0]    store_d [NP];
  logic [6:0]    time_q  [NP];
  logic [6:0]    time_d  [NP];
  logic [NP-1:0] done_q, done_d;

  logic [2:0]    fish     [NP];
  logic [2:0]    gain     [NP];
  logic [5:0]    new_sum  [NP];

  logic          bitti_q, bitti_d;
  logic [6:0]    en_kisa_q, en_kisa_d;
  logic [6:0]    en_uzun_q, en_uzun_d;
  logic [6:0]    ortalama_q, ortalama_d;
  logic [2:0]    hizli_q, hizli_d;
  logic [2:0]    yavas_q, yavas_d;

  logic [6:0]    mn, mx;
  logic [2:0]    mn_i, mx_i;
  logic [9:0]    total;
  logic [9:0]    mean;

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      store_d[k] = store_q[k];
      time_d[k]  = time_q[k];
      done_d[k]  = done_q[k];
      fish[k]    = avlanan_balik[3*k +: 3];
      // One fish eaten per cycle; an empty catch costs nothing.
      gain[k]    = (fish[k] == 3'd0) ? 3'd0 : fish[k] - 3'd1;
      new_sum[k] = {1'b0, store_q[k]} + {3'b000, gain[k]};
      if (!done_q[k]) begin
        time_d[k]  = (time_q[k] == 7'd127) ? time_q[k] : time_q[k] + 7'd1;
        store_d[k] = new_sum[k][4:0];
        if (new_sum[k] >= 6'd24) done_d[k] = 1'b1;
`ifdef PENGUEN_TIMEOUT_EN
        if (time_d[k] == 7'd127) done_d[k] = 1'b1;
`else
`endif
      end
    end
  end

  // Ties resolve to the highest index, hence <= and >= while scanning upward.
  always_comb begin
    mn    = time_q[0];
    mx    = time_q[0];
    mn_i  = 3'd1;
    mx_i  = 3'd1;
    total = {3'b000, time_q[0]};
    for (int k = 1; k < NP; k++) begin
      if (time_q[k] <= mn) begin
        mn   = time_q[k];
        mn_i = 3'(k + 1);
      end
      if (time_q[k] >= mx) begin
        mx   = time_q[k];
        mx_i = 3'(k + 1);
      end
      total = total + {3'b000, time_q[k]};
    end
    mean = total / 10'd5;
  end

  always_comb begin
    bitti_d    = bitti_q;
    en_kisa_d  = en_kisa_q;
    en_uzun_d  = en_uzun_q;
    ortalama_d = ortalama_q;
    hizli_d    = hizli_q;
    yavas_d    = yavas_q;
    if ((&done_q) && !bitti_q) begin
      bitti_d    = 1'b1;
      en_kisa_d  = mn;
      en_uzun_d  = mx;
      ortalama_d = mean[6:0];
      hizli_d    = mn_i;
      yavas_d    = mx_i;
    end
  end

  always_ff @(posedge saat or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NP; k++) begin
        store_q[k] <= 5'd0;
        time_q[k]  <= 7'd0;
      end
      done_q     <= '0;
      bitti_q    <= 1'b0;
      en_kisa_q  <= 7'd0;
      en_uzun_q  <= 7'd0;
      ortalama_q <= 7'd0;
      hizli_q    <= 3'd0;
      yavas_q    <= 3'd0;
    end else begin
      for (int k = 0; k < NP; k++) begin
        store_q[k] <= store_d[k];
        time_q[k]  <= time_d[k];
      end
      done_q     <= done_d;
      bitti_q    <= bitti_d;
      en_kisa_q  <= en_kisa_d;
      en_uzun_q  <= en_uzun_d;
      ortalama_q <= ortalama_d;
      hizli_q    <= hizli_d;
      yavas_q    <= yavas_d;
    end
  end

  assign bitti         = bitti_q;
  assign en_kisa       = en_kisa_q;
  assign en_uzun       = en_uzun_q;
  assign ortalama      = ortalama_q;
  assign hizli_penguen = hizli_q;
  assign yavas_penguen = yavas_q;

endmodule

// File: tb/tb_penguenler.sv
// Directed bench for penguenler: hand-computed race outcomes checked per scenario.
module tb_penguenler;

  logic        saat;
  logic        reset;
  logic [14:0] avlanan_balik;
  logic        bitti;
  logic [6:0]  en_kisa, en_uzun, ortalama;
  logic [2:0]  hizli_penguen, yavas_penguen;

  int tests_run;
  int tests_failed;

  penguenler dut (
    .saat          (saat),
    .reset         (reset),
    .avlanan_balik (avlanan_balik),
    .bitti         (bitti),
    .en_kisa       (en_kisa),
    .en_uzun       (en_uzun),
    .ortalama      (ortalama),
    .hizli_penguen (hizli_penguen),
    .yavas_penguen (yavas_penguen)
  );

  initial saat = 1'b0;
  always #5 saat = ~saat;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic run(input logic [14:0] pat, input int n);
    avlanan_balik = pat;
    repeat (n) @(posedge saat);
    #1;
  endtask

  task automatic do_reset();
    avlanan_balik = 15'd0;
    reset = 1'b0;
    repeat (2) @(posedge saat);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_all(input string name, input logic b, input logic [6:0] mn,
                           input logic [6:0] mx, input logic [6:0] av,
                           input logic [2:0] hz, input logic [2:0] yv);
    tests_run++;
    if (bitti !== b) begin
      tests_failed++;
      $display("FAIL %s.bitti got %0b want %0b", name, bitti, b);
    end
    tests_run++;
    if (en_kisa !== mn) begin
      tests_failed++;
      $display("FAIL %s.en_kisa got %0d want %0d", name, en_kisa, mn);
    end
    tests_run++;
    if (en_uzun !== mx) begin
      tests_failed++;
      $display("FAIL %s.en_uzun got %0d want %0d", name, en_uzun, mx);
    end
    tests_run++;
    if (ortalama !== av) begin
      tests_failed++;
      $display("FAIL %s.ortalama got %0d want %0d", name, ortalama, av);
    end
    tests_run++;
    if (hizli_penguen !== hz) begin
      tests_failed++;
      $display("FAIL %s.hizli got %0d want %0d", name, hizli_penguen, hz);
    end
    tests_run++;
    if (yavas_penguen !== yv) begin
      tests_failed++;
      $display("FAIL %s.yavas got %0d want %0d", name, yavas_penguen, yv);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_all("reset", 1'b0, 7'd0, 7'd0, 7'd0, 3'd0, 3'd0);
  endtask

  task automatic test_all_fast();
    do_reset();
    run(15'b111_111_111_111_111, 4);
    tests_run++;
    if (bitti !== 1'b0) begin
      tests_failed++;
      $display("FAIL fast_latency bitti got %0b want 0", bitti);
    end
    run(15'b111_111_111_111_111, 1);
    check_all("fast_edge5", 1'b1, 7'd4, 7'd4, 7'd4, 3'd5, 3'd5);
    run(15'b111_111_111_111_111, 15);
    check_all("fast_hold", 1'b1, 7'd4, 7'd4, 7'd4, 3'd5, 3'd5);
  endtask

  task automatic test_late_five();
    do_reset();
    run(15'b001_001_001_001_111, 5);
    tests_run++;
    if (bitti !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_early bitti got %0b want 0", bitti);
    end
    run(15'b111_111_111_111_000, 4);
    tests_run++;
    if (bitti !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_edge9 bitti got %0b want 0", bitti);
    end
    run(15'b111_111_111_111_000, 1);
    check_all("late", 1'b1, 7'd4, 7'd9, 7'd8, 3'd1, 3'd5);
  endtask

  task automatic test_mixed();
    do_reset();
    run(15'b001_111_101_011_011, 5);
    run(15'b111_011_111_011_011, 20);
    check_all("mixed", 1'b1, 7'd4, 7'd12, 7'd8, 3'd4, 3'd2);
  endtask

  task automatic test_async_reset();
    reset = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 7'd0, 7'd0, 7'd0, 3'd0, 3'd0);
  endtask

  task automatic test_no_fill();
    do_reset();
`ifdef PENGUEN_TIMEOUT_EN
    run(15'b001_001_001_001_001, 127);
    tests_run++;
    if (bitti !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_127 bitti got %0b want 0", bitti);
    end
    run(15'b001_001_001_001_001, 1);
    check_all("timeout_128", 1'b1, 7'd127, 7'd127, 7'd127, 3'd5, 3'd5);
`else
    run(15'b001_001_001_001_001, 200);
    check_all("no_fill", 1'b0, 7'd0, 7'd0, 7'd0, 3'd0, 3'd0);
`endif
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b0;
    avlanan_balik = 15'd0;
    test_reset();
    test_all_fast();
    test_late_five();
    test_mixed();
    test_async_reset();
    test_no_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/penguenler.md
# penguenler

Penguin foraging race tracker. Five penguins each report a 3-bit catch per clock; each penguin's net store grows until it is full, and the cycle count at which that happens is latched as the penguin's finish time. Once all five have finished, the block publishes fastest/slowest times, their penguin indices, and the mean time. It is a standalone statistics block driven by an upstream catch source.

## Interface
- No parameters. Constants: 5 penguins, fill target 24, time width 7 bits.
- saat  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- avlanan_balik  input  15  per-cycle catch; penguin k (1..5) uses bits [3k-1:3k-3], so penguin 1 is [2:0] and penguin 5 is [14:12].
- bitti  output  1  all five penguins finished; statistics valid.
- en_kisa  output  7  shortest finish time, in cycles.
- en_uzun  output  7  longest finish time, in cycles.
- ortalama  output  7  floor(sum of the five finish times / 5).
- hizli_penguen  output  3  index 1..5 of the fastest penguin.
- yavas_penguen  output  3  index 1..5 of the slowest penguin.

## Operation
- Per penguin state: 5-bit store, 7-bit time counter, done flag.
- Each cycle for a penguin that is not done:
  - Time counter increments, saturating at 127.
  - Store gains max(v-1, 0), where v is the penguin's 3-bit field. The penguin eats one fish per cycle; v=0 costs nothing.
- Done rule: the penguin is done when the new store is 24 or more. Its finish time is the incremented counter value from that same edge. Store, time and done then freeze until reset.
- Once done, a penguin ignores further input.
- Statistics are computed after all five done flags are set:
  - en_kisa and en_uzun are the minimum and maximum finish times.
  - Sum the times in a 10-bit adder (maximum 635), then divide by the constant 5 with floor to get ortalama.
- Tie rule: when several penguins share the minimum or maximum time, report the highest index. If all five tie, hizli_penguen = yavas_penguen = 5.
- Outputs:
  - All outputs are 0 until bitti.
  - After bitti, the values hold unchanged until reset.
  - No other state machine: IDLE/RUN is implied by the done flags, and DONE by bitti.

## Timing
- Reset asserted: all stores, counters, done flags and outputs go to 0 immediately (asynchronous). The reset value of every output is 0.
- Cycle numbering: cycle 1 is the first rising edge after reset deasserts. A penguin filled on edge n has time n.
- Latency: bitti and all statistics register on the edge after the last done flag sets, i.e. last finish time + 1.
- Reset mid-run or after bitti restarts everything from cycle 1 and drops bitti asynchronously.
- Several penguins finishing on the same edge is legal; all latch the same time.
- Fastest possible finish is 4 cycles (v=7 gives +6 per cycle).

## Configuration
- PENGUEN_TIMEOUT_EN defined: a penguin not done when its counter reaches 127 is forced done with time 127, so bitti always asserts by cycle 128.
- PENGUEN_TIMEOUT_EN undefined: a penguin that never fills stays not done, and bitti stays 0 indefinitely. Counters still saturate at 127.

## Test plan
- Reset, then all fields 111 for 20 cycles:
  - bitti=1, en_kisa=4, en_uzun=4, ortalama=4, hizli=5, yavas=5.
- Reset, then 001_001_001_001_111 for 5 cycles:
  - bitti=0.
  - Then 111_111_111_111_000 for 5 cycles: bitti=1, en_kisa=4, en_uzun=9, ortalama=8, hizli=1, yavas=5.
- Reset, then 001_111_101_011_011 for 5 cycles, then 111_011_111_011_011 held:
  - bitti=1, en_kisa=4, en_uzun=12, ortalama=8, hizli=4, yavas=2.
- Assert reset after bitti=1:
  - All outputs read 0 immediately, before the next edge.
- All fields 001 for 200 cycles:
  - With PENGUEN_TIMEOUT_EN: bitti=1 at cycle 128 with every time 127, hizli=5, yavas=5.
  - Without PENGUEN_TIMEOUT_EN: bitti stays 0.
